// File: rtl/spi_pin_ctrl_pkg.sv
// rtl/spi_pin_ctrl_pkg.sv - shared types and constants for the SPI LED pin controller
package spi_pin_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        DATA  = 3'd2,
        EXEC  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [7:0] OP_LED_WR = 8'h01;
    localparam logic [7:0] OP_MODE   = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_CLR    = 8'h04;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_REG  = 1'b1;

    localparam int FRAME_BITS = 16;
    localparam int BYTE_BITS  = FRAME_BITS / 2;

endpackage

// File: rtl/spi_pin_ctrl_if.sv
// rtl/spi_pin_ctrl_if.sv - SPI pin bundle between external master and the controller
interface spi_pin_ctrl_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        input  miso
    );

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/spi_pin_ctrl_sync_edge.sv
// rtl/spi_pin_ctrl_sync_edge.sv - multi-flop synchronizer with registered edge detect
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the chain and keep the previous synced level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_pin_ctrl.sv
// rtl/spi_pin_ctrl.sv - SPI slave that drives the test LED bank from pins or registers
module spi_pin_ctrl
    import spi_pin_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LED_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_pin_ctrl_if.slave     spi,
    input  logic              in1,
    input  logic              in2,
    output logic [LED_W-1:0]  leds,
    output logic              busy,
    output logic              frame_err
);

    logic sclk_rise;
    logic sclk_fall;
    logic sclk_lvl;
    logic cs_rise;
    logic cs_fall;
    logic cs_lvl;

    // sclk idles low in mode 0, so reset the chain low to avoid a phantom edge.
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (spi.sclk),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // cs_n chain resets low: a cs_n held low through reset produces no fall,
    // so a frame can only start after a genuine high-then-low.
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (spi.cs_n),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] in1_sync_q;
    logic [SYNC_STAGES-1:0] in2_sync_q;
    logic                   mosi_lvl;
    logic                   in1_lvl;
    logic                   in2_lvl;

    // Level-only synchronizers for data and test pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            in1_sync_q  <= '0;
            in2_sync_q  <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            in1_sync_q  <= {in1_sync_q[SYNC_STAGES-2:0], in1};
            in2_sync_q  <= {in2_sync_q[SYNC_STAGES-2:0], in2};
        end
    end

    assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];
    assign in1_lvl  = in1_sync_q[SYNC_STAGES-1];
    assign in2_lvl  = in2_sync_q[SYNC_STAGES-1];

    state_e           state_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       cmd_q;
    logic [7:0]       data_q;
    // tx_sh_q[8] is the bit on the wire; the extra bit lets a byte reload keep the
    // current bit on miso until the following sclk fall promotes the new MSB.
    logic [8:0]       tx_sh_q;
    logic             miso_q;
    logic             busy_q;
    logic             frame_err_q;
    logic [LED_W-1:0] led_reg_q;
    logic             mode_q;
    logic [LED_W-1:0] leds_q;

    // Frame sequencer: bit collection, status shift-out and command execution
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            tx_sh_q     <= '0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            led_reg_q   <= '0;
            mode_q      <= MODE_PASS;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= CMD;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        tx_sh_q   <= {leds_q, 1'b0};
                        miso_q    <= leds_q[7];
                    end
                end
                CMD, DATA: begin
                    if (cs_rise) begin
                        // Abort wins over any sclk edge in the same cycle.
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                        bit_cnt_q   <= '0;
                        miso_q      <= 1'b0;
                    end else if (sclk_rise) begin
                        if (state_q == CMD) begin
                            cmd_q <= {cmd_q[6:0], mosi_lvl};
                        end else begin
                            data_q <= {data_q[6:0], mosi_lvl};
                        end
                        if (bit_cnt_q == 4'(BYTE_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (state_q == CMD) begin
                                state_q <= DATA;
                                tx_sh_q <= {tx_sh_q[8], 7'b0, mode_q};
                            end else begin
                                state_q <= EXEC;
                                miso_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (sclk_fall) begin
                        tx_sh_q <= {tx_sh_q[7:0], 1'b0};
                        miso_q  <= tx_sh_q[7];
                    end
                end
                EXEC: begin
                    miso_q  <= 1'b0;
                    state_q <= DRAIN;
                    case (cmd_q)
                        OP_LED_WR: led_reg_q <= data_q;
                        OP_MODE:   mode_q    <= data_q[0];
                        OP_READ:   ;
                        OP_CLR:    led_reg_q <= '0;
                        default:   frame_err_q <= 1'b1;
                    endcase
                end
                DRAIN: begin
                    // Level test also catches a cs_n rise that landed during EXEC.
                    miso_q <= 1'b0;
                    if (cs_lvl) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end

    // LED drive: register value in register mode, replicated pins in passthrough
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds_q <= '0;
        end else if (mode_q == MODE_REG) begin
            leds_q <= led_reg_q;
        end else begin
            leds_q <= {{4{in1_lvl}}, {4{in2_lvl}}};
        end
    end

    assign spi.miso  = miso_q;
    assign leds      = leds_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_pin_ctrl.sv
// tb/tb_spi_pin_ctrl.sv - self-checking bench for spi_pin_ctrl
module tb_spi_pin_ctrl;

    localparam int HP = 8;

    logic       clk;
    logic       rst_n;
    logic       in1;
    logic       in2;
    logic [7:0] leds;
    logic       busy;
    logic       frame_err;

    spi_pin_ctrl_if spi_if ();

    spi_pin_ctrl #(.SYNC_STAGES(2), .LED_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi_if),
        .in1       (in1),
        .in2       (in2),
        .leds      (leds),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  data;
        int          nbits;
        logic [7:0]  exp_leds;
        int          exp_err;
        logic [23:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic m, output logic bsy);
        spi_if.mosi = b;
        wait_clks(HP);
        m   = spi_if.miso;
        bsy = busy;
        spi_if.sclk = 1'b1;
        wait_clks(HP);
        spi_if.sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                             output logic [23:0] rd, output logic busy_all);
        logic [23:0] word;
        logic        m;
        logic        bsy;
        word     = {cmd, data, 8'h00};
        rd       = '0;
        busy_all = 1'b1;
        spi_if.cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(word[23-i], m, bsy);
            rd       = {rd[22:0], m};
            busy_all = busy_all & bsy;
        end
        wait_clks(HP);
        busy_all = busy_all & busy;
        spi_if.cs_n = 1'b1;
        wait_clks(2 * HP);
    endtask

    logic [23:0] rd;
    logic        busy_all;
    logic        m;
    logic        bsy;
    logic        busy_seen;
    int          err_before;

    initial begin
        vecs[0] = '{cmd: 8'h02, data: 8'h01, nbits: 16, exp_leds: 8'h00, exp_err: 0, exp_rd: 24'h000F00};
        vecs[1] = '{cmd: 8'h01, data: 8'hA5, nbits: 16, exp_leds: 8'hA5, exp_err: 0, exp_rd: 24'h000001};
        vecs[2] = '{cmd: 8'h03, data: 8'h00, nbits: 16, exp_leds: 8'hA5, exp_err: 0, exp_rd: 24'h00A501};
        vecs[3] = '{cmd: 8'h7E, data: 8'hFF, nbits: 16, exp_leds: 8'hA5, exp_err: 1, exp_rd: 24'h00A501};
        vecs[4] = '{cmd: 8'h04, data: 8'h00, nbits: 24, exp_leds: 8'h00, exp_err: 0, exp_rd: 24'hA50100};
        vecs[5] = '{cmd: 8'h01, data: 8'h5A, nbits: 16, exp_leds: 8'h5A, exp_err: 0, exp_rd: 24'h000001};

        rst_n       = 1'b0;
        in1         = 1'b0;
        in2         = 1'b0;
        spi_if.sclk = 1'b0;
        spi_if.cs_n = 1'b1;
        spi_if.mosi = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;

        check("reset_leds", 32'(leds), 32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_miso", 32'(spi_if.miso), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        wait_clks(4);

        // Passthrough: pins reach leds after exactly three clocks
        in1 = 1'b1;
        in2 = 1'b0;
        wait_clks(2);
        check("pass_latency_early", 32'(leds), 32'h00);
        wait_clks(1);
        check("pass_f0", 32'(leds), 32'hF0);
        in1 = 1'b0;
        in2 = 1'b1;
        wait_clks(3);
        check("pass_0f", 32'(leds), 32'h0F);

        // Table of full frames; pins are flipped afterwards and must not matter in register mode
        for (int i = 0; i < 6; i++) begin
            err_before = err_cnt;
            spi_frame(vecs[i].cmd, vecs[i].data, vecs[i].nbits, rd, busy_all);
            check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
            check($sformatf("vec%0d_err", i), 32'(err_cnt - err_before), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_miso", i), 32'(rd), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_busy_in_frame", i), 32'(busy_all), 32'h1);
            check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'h0);
            in1 = ~in1;
            in2 = ~in2;
            wait_clks(5);
            check($sformatf("vec%0d_pins_ignored", i), 32'(leds), 32'(vecs[i].exp_leds));
        end

        // Abort after 11 rises: one error pulse, no command
        err_before = err_cnt;
        spi_frame(8'h01, 8'h3C, 11, rd, busy_all);
        check("abort_err_pulses", 32'(err_cnt - err_before), 32'd1);
        check("abort_leds", 32'(leds), 32'h5A);
        check("abort_busy", 32'(busy), 32'h0);
        err_before = err_cnt;
        spi_frame(8'h01, 8'h3C, 16, rd, busy_all);
        check("after_abort_leds", 32'(leds), 32'h3C);
        check("after_abort_err", 32'(err_cnt - err_before), 32'd0);

        // Reset mid-DATA with cs_n held low
        in1 = 1'b0;
        in2 = 1'b0;
        err_before = err_cnt;
        spi_if.cs_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spi_bit(((16'h01C3 >> (15 - i)) & 16'h1) != 0, m, bsy);
        end
        rst_n = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        check("midrst_leds", 32'(leds), 32'h00);
        check("midrst_busy", 32'(busy), 32'h0);
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b1, m, bsy);
            busy_seen = busy_seen | bsy | busy;
        end
        check("midrst_no_start", 32'(busy_seen), 32'h0);
        check("midrst_no_err", 32'(err_cnt - err_before), 32'd0);
        check("midrst_leds_held", 32'(leds), 32'h00);
        spi_if.cs_n = 1'b1;
        wait_clks(2 * HP);
        spi_frame(8'h02, 8'h01, 16, rd, busy_all);
        check("post_rst_mode_miso", 32'(rd), 32'h000000);
        spi_frame(8'h01, 8'h81, 16, rd, busy_all);
        check("post_rst_leds", 32'(leds), 32'h81);
        check("post_rst_miso", 32'(rd), 32'h000001);
        check("post_rst_err", 32'(err_cnt - err_before), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_pin_ctrl.md
Name: spi_pin_ctrl

Overview:
SPI-slave controller that configures and sequences the board's test LED bank from an external SPI master. It synchronizes the asynchronous SPI and pin inputs into the system clock domain and decodes fixed 16-bit frames (command byte, data byte). Two LED modes exist: pin-passthrough, where the two test pins drive the LED nibbles, and register mode, where SPI-written values drive the LEDs. It also returns LED/mode status on MISO.

Parameters:
SYNC_STAGES, 2, flop depth of each input synchronizer (min 2)
LED_W, 8, LED bus width; fixed at 8 for this revision

Ports:
clk    in   1      system clock
rst_n  in   1      reset, synchronous, active-low
sclk   in   1      SPI clock, asynchronous, mode 0 (CPOL=0, CPHA=0)
cs_n   in   1      SPI chip select, asynchronous, active-low
mosi   in   1      SPI data in, MSB first
miso   out  1      SPI data out, MSB first; 0 while no frame is active
in1    in   1      test pin, asynchronous; drives leds[7:4] in passthrough mode
in2    in   1      test pin, asynchronous; drives leds[3:0] in passthrough mode
leds   out  LED_W  registered LED drive
busy   out  1      high whenever state != IDLE
frame_err out 1    one-cycle pulse on an aborted frame or an unknown opcode

Behaviour:
- Sync: sclk, cs_n, mosi, in1, in2 each pass through SYNC_STAGES flops. sclk and cs_n also get an edge-detect flop.
- Edge flops: sclk rise = sample MOSI; sclk fall = advance MISO.
- SPI clock limit: f_sclk <= f_clk/8.
- Reset: leds=0, led_reg=0, mode=0, miso=0, busy=0, frame_err=0, state=IDLE, bit_cnt=0.
- Reset asserted mid-frame aborts the frame silently: no command executes and frame_err stays 0.
- After reset, a frame starts only after synced cs_n has been seen high and then low. cs_n held low through reset must not start a frame.
- FSM states:
  - IDLE: on synced cs_n fall, go to CMD. Clear bit_cnt. Load tx_sh with status byte 0 = current leds value. Drive miso = tx_sh[7].
  - CMD: each sclk rise shifts mosi into cmd LSB-side. On the 8th rise, go to DATA, clear bit_cnt, load tx_sh with status byte 1 = {7'b0, mode}.
  - DATA: same sampling into data. On the 8th rise, go to EXEC.
  - EXEC: exactly one cycle; apply the command, then go to DRAIN.
  - DRAIN: ignore all sclk edges. On synced cs_n rise, go to IDLE.
- Abort: synced cs_n rises in CMD or DATA before 16 rises. Pulse frame_err for 1 cycle, go to IDLE, leave led_reg and mode unchanged.
- MISO shifting: each sclk fall in CMD/DATA shifts tx_sh left; miso = tx_sh[7]. A byte-boundary reload takes priority over a shift in the same cycle. miso = 0 in IDLE and DRAIN.
- Opcodes, decoded in EXEC:
  - 0x01 LED_WR: led_reg <= data
  - 0x02 MODE: mode <= data[0]
  - 0x03 READ: no state change (status already shifted out)
  - 0x04 CLR: led_reg <= 0
  - any other value: no change, frame_err pulse in the EXEC cycle
- leds register, updated every cycle:
  - mode=1: leds <= led_reg
  - mode=0: leds[7:4] <= {4{in1_sync}}, leds[3:0] <= {4{in2_sync}}
- Latency: command visible on leds exactly 1 clk after EXEC. Pin to leds in passthrough: SYNC_STAGES+1 clks.
- Simultaneous sclk rise and cs_n rise in the same cycle: the abort check wins and the sample is discarded.

Decomposition:
- Package spi_pin_pkg:
  - state enum {IDLE, CMD, DATA, EXEC, DRAIN}
  - opcode localparams OP_LED_WR=8'h01, OP_MODE=8'h02, OP_READ=8'h03, OP_CLR=8'h04
  - MODE_PASS=1'b0, MODE_REG=1'b1
  - FRAME_BITS=16
- One sub-module, sync_edge: SYNC_STAGES synchronizer plus a registered previous value, with outputs level, rise, fall and a reset-value parameter.
  - Instanced for sclk and cs_n.
  - Level output only used for mosi, in1, in2.

Test Plan:
1. Reset, mode 0, in1=1, in2=0 -> leds=0xF0 by 3 clks after pin settle. Then in1=0, in2=1 -> leds=0x0F.
2. Frame 0x02,0x01, then frame 0x01,0xA5 -> leds=0xA5 one clk after second EXEC. Toggling in1/in2 afterwards leaves leds=0xA5.
3. Readback: leds=0xA5, mode=1, frame 0x03,0x00 -> MISO bits read 0xA5 then 0x01. led_reg/mode unchanged. busy high from cs_n fall to DRAIN exit.
4. Abort: cs_n raised after 11 sclk rises of frame 0x01,0x3C -> exactly one frame_err pulse, leds unchanged. Next full frame 0x01,0x3C -> leds=0x3C.
5. Opcodes: frame 0x7E,0xFF -> frame_err pulse, no change. Frame 0x04,0x00 -> leds=0x00. Extra 8 sclk after 16 bits with cs_n low -> no second execution.
6. rst_n low for 2 clks mid-DATA with cs_n held low -> IDLE, leds=0, no frame_err, no frame start until cs_n goes high then low. The following frame 0x02,0x01 executes normally.
